match_stats: RTL



---
 rtl/match_stats_pkg.sv | 13 +
 rtl/match_stats_sat.sv | 39 +++
 rtl/match_stats.sv | 112 +++++++++++
 3 files changed

// File: rtl/match_stats_pkg.sv
// Shared types and default widths for the match_stats frame statistics block.
package match_stats_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int RUN_W_DEF = 8;

    // The state encoding doubles as rpt_valid.
    typedef enum logic {
        ACCUM   = 1'b0,
        PENDING = 1'b1
    } state_e;

endpackage

// File: rtl/match_stats_sat.sv
// Saturating up-counter with clear; also exposes the saturated increment of the
// current value so the owner can build look-ahead values from it.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic [W-1:0] sat_inc
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        sat_inc = (value_q == '1) ? value_q : value_q + W'(1);
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = sat_inc;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/match_stats.sv
// Per-frame match statistics: counts rising edges of ans and the longest ans=1
// run, snapshots them at frame_end and offers the report on a valid/ready port.
module match_stats
    import match_stats_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RUN_W = RUN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ans,
    input  logic             frame_end,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_count,
    output logic [RUN_W-1:0] rpt_max_run,
    output logic             overrun
);

    state_e           state_q, state_d;
    logic             prev_ans_q;
    logic [RUN_W-1:0] max_run_q, max_run_d;
    logic [CNT_W-1:0] rpt_count_q;
    logic [RUN_W-1:0] rpt_max_run_q;
    logic             overrun_q, overrun_d;
    logic             load_rpt;

    logic             evt;
    logic [CNT_W-1:0] cnt, cnt_inc, cnt_n;
    logic [RUN_W-1:0] run_inc, run_n, max_n;
    // The current run length is only needed through its saturated increment.
    logic [RUN_W-1:0] run_unused;

    assign evt = ans & ~prev_ans_q;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (evt),
        .clr     (frame_end),
        .value   (cnt),
        .sat_inc (cnt_inc)
    );

    sat_counter #(.W(RUN_W)) u_run (
        .clk     (clk),
        .reset   (reset),
        .inc     (ans),
        .clr     (frame_end | ~ans),
        .value   (run_unused),
        .sat_inc (run_inc)
    );

    // Look-ahead values include the current cycle, so the frame_end sample lands in the closing frame.
    always_comb begin
        cnt_n     = evt ? cnt_inc : cnt;
        run_n     = ans ? run_inc : '0;
        max_n     = (run_n > max_run_q) ? run_n : max_run_q;
        max_run_d = frame_end ? '0 : max_n;
    end

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        load_rpt  = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (frame_end) begin
                    load_rpt = 1'b1;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (rpt_ready) begin
                    if (frame_end) begin
                        load_rpt = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end else if (frame_end) begin
                    overrun_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ACCUM;
            prev_ans_q    <= 1'b0;
            max_run_q     <= '0;
            rpt_count_q   <= '0;
            rpt_max_run_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_ans_q <= ans;
            max_run_q  <= max_run_d;
            overrun_q  <= overrun_d;
            if (load_rpt) begin
                rpt_count_q   <= cnt_n;
                rpt_max_run_q <= max_n;
            end
        end
    end

    assign rpt_valid   = (state_q == PENDING);
    assign rpt_count   = rpt_count_q;
    assign rpt_max_run = rpt_max_run_q;
    assign overrun     = overrun_q;

endmodule
